nios_system_led_dimmer: RTL and testbench



---
 rtl/nios_system_led_dimmer_pkg.sv | 24 ++
 rtl/nios_system_led_dimmer_if.sv | 16 +
 rtl/nios_system_led_pwm_timebase.sv | 46 ++++
 rtl/nios_system_led_dimmer.sv | 137 +++++++++++++
 tb/tb_nios_system_led_dimmer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/nios_system_led_dimmer_pkg.sv
// Shared definitions for the LED dimmer: register addresses, CTRL bit
// positions, register reset values and the PWM counter ceiling.
package nios_system_led_dimmer_pkg;

  typedef enum logic [1:0] {
    REG_CTRL       = 2'd0,
    REG_DUTY       = 2'd1,
    REG_PRESCALE   = 2'd2,
    REG_BLINK_HALF = 2'd3
  } reg_addr_e;

  localparam int unsigned CTRL_ENABLE   = 0;
  localparam int unsigned CTRL_BLINK_EN = 1;
  localparam int unsigned CTRL_INVERT   = 2;

  localparam logic [2:0]  CTRL_RESET       = 3'b001;
  localparam logic [7:0]  DUTY_RESET       = 8'hFF;
  localparam int unsigned PRESCALE_RESET   = 0;
  localparam int unsigned BLINK_HALF_RESET = 255;

  // pwm_cnt runs 0..PWM_MAX, giving a 255-tick period
  localparam logic [7:0]  PWM_MAX = 8'd254;

endpackage

// File: rtl/nios_system_led_dimmer_if.sv
// Avalon-MM slave bus of the LED dimmer.
//   address    : register select
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : combinational read data
interface nios_system_led_dimmer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_system_led_pwm_timebase.sv
// PWM timebase: prescaler producing a tick every PRESCALE+1 cycles and the
// 0..254 PWM counter advanced on tick.
//   clk, reset_n : clock, async active-low reset
//   enable       : counters run when 1, held at 0 otherwise
//   clear        : restart prescaler and pwm_cnt; suppresses this cycle's tick
//   prescale     : prescaler terminal count
//   pwm_cnt      : current PWM position
//   period_end   : tick on the last PWM position
module nios_system_led_pwm_timebase
  import nios_system_led_dimmer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [7:0]            pwm_cnt,
  output logic                  period_end
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  tick;

  assign tick       = enable && !clear && (pre_cnt == prescale);
  assign period_end = tick && (pwm_cnt == PWM_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (!enable || clear) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      pwm_cnt <= period_end ? 8'd0 : pwm_cnt + 8'd1;
    end else begin
      pre_cnt <= pre_cnt + ONE;
    end
  end

endmodule

// File: rtl/nios_system_led_dimmer.sv
// LED dimmer between the green-LED PIO and the LEDG pins: global PWM
// brightness, optional blinking and output inversion, configured over an
// Avalon-MM slave with zero-wait-state reads.
//   clk, reset_n : clock, async active-low reset
//   bus          : Avalon-MM slave (CTRL, DUTY, PRESCALE, BLINK_HALF)
//   led_in       : LED pattern from the PIO out_port
//   led_out      : registered LED pin drive
module nios_system_led_dimmer
  import nios_system_led_dimmer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 16,
  parameter int unsigned LED_W      = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  nios_system_led_dimmer_if.slave bus,
  input  logic [LED_W-1:0]       led_in,
  output logic [LED_W-1:0]       led_out
);

  localparam logic [PRESCALE_W-1:0] ONE         = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] PRESCALE_RV = PRESCALE_W'(PRESCALE_RESET);
  localparam logic [PRESCALE_W-1:0] BLINK_RV    = PRESCALE_W'(BLINK_HALF_RESET);

  logic [2:0]            ctrl;
  logic [7:0]            duty;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] blink_half;

  logic wr, wr_ctrl, wr_duty, wr_prescale, wr_blink_half;
  logic enable, blink_en, invert;
  logic unused_wdata;

  assign wr            = bus.chipselect && !bus.write_n;
  assign wr_ctrl       = wr && (reg_addr_e'(bus.address) == REG_CTRL);
  assign wr_duty       = wr && (reg_addr_e'(bus.address) == REG_DUTY);
  assign wr_prescale   = wr && (reg_addr_e'(bus.address) == REG_PRESCALE);
  assign wr_blink_half = wr && (reg_addr_e'(bus.address) == REG_BLINK_HALF);
  assign unused_wdata  = &{1'b0, bus.writedata};

  assign enable   = ctrl[CTRL_ENABLE];
  assign blink_en = ctrl[CTRL_BLINK_EN];
  assign invert   = ctrl[CTRL_INVERT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl       <= CTRL_RESET;
      duty       <= DUTY_RESET;
      prescale   <= PRESCALE_RV;
      blink_half <= BLINK_RV;
    end else begin
      if (wr_ctrl)       ctrl       <= bus.writedata[2:0];
      if (wr_duty)       duty       <= bus.writedata[7:0];
      if (wr_prescale)   prescale   <= bus.writedata[PRESCALE_W-1:0];
      if (wr_blink_half) blink_half <= bus.writedata[PRESCALE_W-1:0];
    end
  end

  always_comb begin
    bus.readdata = '0;
    unique case (reg_addr_e'(bus.address))
      REG_CTRL:       bus.readdata[2:0]            = ctrl;
      REG_DUTY:       bus.readdata[7:0]            = duty;
      REG_PRESCALE:   bus.readdata[PRESCALE_W-1:0] = prescale;
      REG_BLINK_HALF: bus.readdata[PRESCALE_W-1:0] = blink_half;
      default:        bus.readdata                 = '0;
    endcase
  end

  logic [7:0] pwm_cnt;
  logic       period_end;

  nios_system_led_pwm_timebase #(
    .PRESCALE_W(PRESCALE_W)
  ) u_timebase (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .clear     (wr_prescale),
    .prescale  (prescale),
    .pwm_cnt   (pwm_cnt),
    .period_end(period_end)
  );

  // Duty shadow: normally follows DUTY only at period_end; the first DUTY
  // write after reset or while/after being disabled takes effect at once.
  logic [7:0] duty_act;
  logic       first_pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_act      <= DUTY_RESET;
      first_pending <= 1'b1;
    end else begin
      if (!enable)      first_pending <= 1'b1;
      else if (wr_duty) first_pending <= 1'b0;

      if (wr_duty && (first_pending || period_end)) duty_act <= bus.writedata[7:0];
      else if (period_end)                          duty_act <= duty;
    end
  end

  logic                  blink_phase;
  logic [PRESCALE_W-1:0] blink_cnt;

  // A count above blink_half (threshold lowered under it) just restarts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (!enable || !blink_en) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (period_end) begin
      if (blink_cnt == blink_half) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else if (blink_cnt > blink_half) begin
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + ONE;
      end
    end
  end

  logic pwm_on, gate;

  assign pwm_on = pwm_cnt < duty_act;
  assign gate   = pwm_on && (!blink_en || blink_phase);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    led_out <= '0;
    else if (enable) led_out <= (led_in & {LED_W{gate}}) ^ {LED_W{invert}};
    else             led_out <= {LED_W{invert}};
  end

endmodule

// File: tb/tb_nios_system_led_dimmer.sv
module tb_nios_system_led_dimmer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] led_in;
  logic [7:0] led_out;

  nios_system_led_dimmer_if bus ();

  nios_system_led_dimmer #(
    .PRESCALE_W(16),
    .LED_W     (8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .led_in (led_in),
    .led_out(led_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t regv [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_set(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  // Called at a falling edge; the write lands on the following rising edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_set(a, d);
    @(negedge clk);
    bus_idle();
  endtask

  // Expected LED value j rising edges after the counters restarted.
  function automatic logic [7:0] pwm_exp(input int j, input int p, input int duty, input logic [7:0] pat);
    int cnt;
    cnt = ((j - 1) / (p + 1)) % 255;
    return (cnt < duty) ? pat : 8'h00;
  endfunction

  initial begin
    int base;

    bus.address   = 2'd0;
    bus.writedata = '0;
    bus_idle();
    led_in = 8'hA5;

    regv[0] = '{1'b0, 2'd0, 32'h0,         32'h1};
    regv[1] = '{1'b0, 2'd1, 32'h0,         32'hFF};
    regv[2] = '{1'b0, 2'd2, 32'h0,         32'h0};
    regv[3] = '{1'b0, 2'd3, 32'h0,         32'hFF};
    regv[4] = '{1'b1, 2'd0, 32'hFFFF_FFF9, 32'h1};
    regv[5] = '{1'b1, 2'd1, 32'h1234_5680, 32'h80};
    regv[6] = '{1'b1, 2'd2, 32'hABCD_0000, 32'h0};
    regv[7] = '{1'b1, 2'd3, 32'hFFFF_0001, 32'h1};

    // reset release with pattern passing straight through
    repeat (3) @(negedge clk);
    check("reset_led", 32'(led_out), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("pass_a5 k=%0d", k), 32'(led_out), 32'hA5);
    end

    // register reads at reset, then masked writes with readback
    for (int i = 0; i < 8; i++) begin
      if (regv[i].wr) bus_write(regv[i].addr, regv[i].wdata);
      bus.address = regv[i].addr;
      #1;
      check($sformatf("reg[%0d]", i), bus.readdata, regv[i].exp);
      @(negedge clk);
    end

    // duty 0x80 (loaded at once as first write), PRESCALE=0 restart
    led_in = 8'hFF;
    bus_write(2'd2, 32'd0);
    for (int k = 1; k <= 510; k++) begin
      @(negedge clk);
      check($sformatf("duty80 k=%0d", k), 32'(led_out), 32'(pwm_exp(k, 0, 128, 8'hFF)));
    end

    // DUTY=0 mid-period takes effect only at period_end
    bus_write(2'd2, 32'd0);
    for (int k = 1; k <= 600; k++) begin
      if (k == 50) bus_set(2'd1, 32'h00);
      @(negedge clk);
      bus_idle();
      check($sformatf("duty00 k=%0d", k), 32'(led_out),
            32'((k <= 255) ? pwm_exp(k, 0, 128, 8'hFF) : 8'h00));
    end

    // DUTY=0xFF written exactly on period_end: shadow takes the new value
    bus_write(2'd2, 32'd0);
    for (int k = 1; k <= 520; k++) begin
      if (k == 255) bus_set(2'd1, 32'hFF);
      @(negedge clk);
      bus_idle();
      check($sformatf("dutyff k=%0d", k), 32'(led_out), 32'((k <= 255) ? 8'h00 : 8'hFF));
    end

    // blinking with BLINK_HALF=1: two periods on, two off
    led_in = 8'h0F;
    bus_write(2'd2, 32'd0);
    bus_write(2'd0, 32'h3);
    for (int k = 2; k <= 1600; k++) begin
      @(negedge clk);
      check($sformatf("blink k=%0d", k), 32'(led_out),
            32'(((((k - 1) / 510) % 2) == 0) ? 8'h0F : 8'h00));
    end

    // PRESCALE=3: 1020-cycle period, rewrite mid-count restarts it
    led_in = 8'hFF;
    bus_write(2'd0, 32'h0);
    bus_write(2'd0, 32'h1);
    bus_write(2'd1, 32'h40);
    bus_write(2'd2, 32'd3);
    base = 0;
    for (int k = 1; k <= 1800; k++) begin
      if (k == 1502) bus_set(2'd2, 32'd3);
      @(negedge clk);
      bus_idle();
      check($sformatf("pre3 k=%0d", k), 32'(led_out), 32'(pwm_exp(k - base, 3, 64, 8'hFF)));
      if (k == 1502) base = 1502;
    end

    // disabled output, immediate duty load after re-enable
    bus_write(2'd0, 32'h0);
    @(negedge clk);
    check("disabled", 32'(led_out), 32'h00);
    led_in = 8'h01;
    bus_write(2'd0, 32'h1);
    bus_write(2'd1, 32'hFF);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      check($sformatf("reenable k=%0d", k), 32'(led_out), 32'h01);
    end

    // inversion enabled and disabled
    bus_write(2'd0, 32'h5);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("invert k=%0d", k), 32'(led_out), 32'hFE);
    end
    bus_write(2'd0, 32'h4);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("invert_off k=%0d", k), 32'(led_out), 32'hFF);
    end

    // asynchronous reset in the middle of a blink-on phase
    led_in = 8'h0F;
    bus_write(2'd0, 32'h3);
    repeat (50) @(negedge clk);
    check("pre_reset", 32'(led_out), 32'h0F);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", 32'(led_out), 32'h00);
    for (int i = 0; i < 4; i++) begin
      bus.address = regv[i].addr;
      #1;
      check($sformatf("reset_reg[%0d]", i), bus.readdata, regv[i].exp);
    end
    @(negedge clk);
    check("reset_hold", 32'(led_out), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
